// File: rtl/cd_cfg_if.sv
// Valid/ready write port carrying one address/data word.
// Used for both the host write side and the CD configuration side.
interface cd_cfg_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 14
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output addr, output data, output valid, input ready);
   modport slave  (input addr, input data, input valid, output ready);
endinterface

// File: rtl/cd_cfg_initiator.sv
// CD configuration initiator: writes the four-entry divider boot table, then forwards host writes.
// Define CD_CFG_TIMEOUT_EN to abort a transfer stalled for TIMEOUT cycles and raise a sticky err_o.
//
// state  | meaning
// IDLE   | no sequence running; host writes and start accepted here
// BOOT   | writing boot table entry idx_q
// HOST   | writing the captured host word
module cd_cfg_initiator #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 14,
   parameter int DIV_VGA  = 2,
   parameter int DIV_UART = 868,
   parameter int DIV_LM   = 1000,
   parameter int DIV_DB   = 5000,
   parameter int TIMEOUT  = 255
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     start_i,
   cd_cfg_if.slave  host,
   cd_cfg_if.master cfg,
   output logic     busy_o,
   output logic     done_o,
   output logic     err_o
);

   typedef enum logic [1:0] {S_IDLE, S_BOOT, S_HOST} state_e;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("cd_cfg_initiator: TIMEOUT must be at least 1");
   end

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        idx_nxt;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pend_q, pend_d;
   logic              xfer;

`ifdef CD_CFG_TIMEOUT_EN
   localparam int STALL_W = (TIMEOUT < 255) ? 8 : $clog2(TIMEOUT + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               err_q, err_d;
`endif

   function automatic logic [DATA_W-1:0] boot_val(input logic [1:0] i);
      logic [DATA_W-1:0] v;
      unique case (i)
         2'd0:    v = DATA_W'(DIV_VGA);
         2'd1:    v = DATA_W'(DIV_UART);
         2'd2:    v = DATA_W'(DIV_LM);
         default: v = DATA_W'(DIV_DB);
      endcase
      return v;
   endfunction

   assign xfer    = valid_q && cfg.ready;
   assign idx_nxt = idx_q + 2'd1;

   // pend_q makes the first edge out of reset behave like a start pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 1'b1;
`ifdef CD_CFG_TIMEOUT_EN
         stall_q <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
`ifdef CD_CFG_TIMEOUT_EN
         stall_q <= stall_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      pend_d  = pend_q;
`ifdef CD_CFG_TIMEOUT_EN
      err_d   = err_q;
      stall_d = stall_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pend_q || start_i) begin
               state_d = S_BOOT;
               idx_d   = 2'd0;
               addr_d  = '0;
               data_d  = boot_val(2'd0);
               valid_d = 1'b1;
               pend_d  = 1'b0;
`ifdef CD_CFG_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end else if (host.valid) begin
               state_d = S_HOST;
               addr_d  = host.addr;
               data_d  = host.data;
               valid_d = 1'b1;
            end
         end
         S_BOOT: begin
            if (xfer) begin
               if (idx_q == 2'd3) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_nxt;
                  addr_d = ADDR_W'(idx_nxt);
                  data_d = boot_val(idx_nxt);
               end
            end
         end
         S_HOST: begin
            if (xfer) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
`ifdef CD_CFG_TIMEOUT_EN
      // counter restarts whenever no word is pending or the current one moves
      if (!valid_q || cfg.ready) begin
         stall_d = '0;
      end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
         stall_d = '0;
         state_d = S_IDLE;
         valid_d = 1'b0;
         err_d   = 1'b1;
      end else begin
         stall_d = stall_q + 1'b1;
      end
`endif
      busy_d = (state_d != S_IDLE);
   end

   always_comb begin
      host.ready = (state_q == S_IDLE) && !start_i && !pend_q && !rst_i;
      cfg.addr   = addr_q;
      cfg.data   = data_q;
      cfg.valid  = valid_q;
      busy_o     = busy_q;
      done_o     = done_q;
`ifdef CD_CFG_TIMEOUT_EN
      err_o      = err_q;
`else
      err_o      = 1'b0;
`endif
   end

endmodule
